mem_access_ctrl: RTL and testbench

//   Multi-cycle controller sequencing the load/store memory stage of the execution cycle.

---
 rtl/mem_access_ctrl_if.sv | 37 +++
 rtl/mem_access_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_ctrl_if
// Brief   : Decode-side, register-file and data-memory signals of the
//           load/store controller.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] Read_data1;
  logic [31:0] Read_data2;
  logic [31:0] address;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] write_data;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic [4:0]  load_rd;
  logic        done;
  logic        err;

  modport master (
    output instr_valid, instruction, Read_data1, Read_data2, mem_ready, mem_rdata,
    input  instr_ready, address, write_enable, read_enable, write_data,
           load_data, load_rd, done, err
  );

  modport slave (
    input  instr_valid, instruction, Read_data1, Read_data2, mem_ready, mem_rdata,
    output instr_ready, address, write_enable, read_enable, write_data,
           load_data, load_rd, done, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_ctrl
// Brief   : Multi-cycle LW/SW memory-stage sequencer (IDLE->ADDR->REQ->DONE).
//           Optional macro MISALIGN_TRAP_EN aborts word-misaligned accesses.
// Revision: 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_REQ  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [5:0]       OP_LW        = 6'b100011;
  localparam logic [5:0]       OP_SW        = 6'b101011;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  logic             is_sw_q;
  logic [4:0]       rt_q;
  logic [15:0]      imm_q;
  logic [31:0]      base_q;
  logic [31:0]      sdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             instr_ready_q;
  logic             we_q;
  logic             re_q;
  logic             done_q;
  logic             err_q;
  logic [31:0]      address_q;
  logic [31:0]      write_data_q;
  logic [31:0]      load_data_q;
  logic [4:0]       load_rd_q;

  logic [5:0]       opcode;
  logic [31:0]      address_d;
  logic             unused_rs;

  assign opcode    = bus.instruction[31:26];
  assign address_d = base_q + {{16{imm_q[15]}}, imm_q};
  assign unused_rs = ^bus.instruction[25:21];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      is_sw_q       <= 1'b0;
      rt_q          <= '0;
      imm_q         <= '0;
      base_q        <= '0;
      sdata_q       <= '0;
      cnt_q         <= '0;
      instr_ready_q <= 1'b0;
      we_q          <= 1'b0;
      re_q          <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      address_q     <= '0;
      write_data_q  <= '0;
      load_data_q   <= '0;
      load_rd_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.instr_valid && instr_ready_q) begin
            instr_ready_q <= 1'b0;
            is_sw_q       <= (opcode == OP_SW);
            rt_q          <= bus.instruction[20:16];
            imm_q         <= bus.instruction[15:0];
            base_q        <= bus.Read_data1;
            sdata_q       <= bus.Read_data2;
            if (opcode == OP_SW || opcode == OP_LW) begin
              state_q <= S_ADDR;
            end else begin
              // Non-memory opcodes retire cleanly without touching memory
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b0;
            end
          end else begin
            instr_ready_q <= 1'b1;
          end
        end

        S_ADDR: begin
          address_q <= address_d;
          cnt_q     <= '0;
          if (is_sw_q) write_data_q <= sdata_q;
`ifdef MISALIGN_TRAP_EN
          if (address_d[1:0] != 2'b00) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            state_q <= S_REQ;
            we_q    <= is_sw_q;
            re_q    <= ~is_sw_q;
          end
`else
          state_q <= S_REQ;
          we_q    <= is_sw_q;
          re_q    <= ~is_sw_q;
`endif
        end

        S_REQ: begin
          if (bus.mem_ready) begin
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            state_q <= S_DONE;
            if (!is_sw_q) begin
              load_data_q <= bus.mem_rdata;
              load_rd_q   <= rt_q;
            end
          end else if (cnt_q == TIMEOUT_LAST) begin
            // Enable has now been visible for TIMEOUT cycles: abort
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_DONE: begin
          done_q        <= 1'b0;
          err_q         <= 1'b0;
          instr_ready_q <= 1'b1;
          state_q       <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_ready  = instr_ready_q;
  assign bus.address      = address_q;
  assign bus.write_enable = we_q;
  assign bus.read_enable  = re_q;
  assign bus.write_data   = write_data_q;
  assign bus.load_data    = load_data_q;
  assign bus.load_rd      = load_rd_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_ctrl
// Brief   : Self-checking bench for mem_access_ctrl with an expected-result
//           queue and a simple memory responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  logic clk;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ld;
    logic [4:0]  rd;
    int          we_n;
    int          re_n;
    int          done_cyc;
    logic        err;
  } exp_t;

  exp_t sb[$];

  // Observations from the most recent instruction
  int          o_we, o_re, o_done_n, o_done_cyc;
  logic        o_both, o_err, o_unstable, o_ready_after, o_to;
  logic [31:0] o_addr, o_wdata, o_ld, o_fin_addr;
  logic [4:0]  o_rd;

  task automatic run_instr(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm,
                           input logic [31:0] rd1, input logic [31:0] rd2,
                           input int wait_n, input logic [31:0] rdata);
    int guard = 0;
    int en_n  = 0;
    @(negedge clk);
    while (bus.instr_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.instruction = {op, 5'd7, rt, imm};
    bus.Read_data1  = rd1;
    bus.Read_data2  = rd2;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instruction = $urandom;
    bus.Read_data1  = $urandom;
    bus.Read_data2  = $urandom;
    o_we = 0; o_re = 0; o_done_n = 0; o_done_cyc = 0;
    o_both = 0; o_err = 0; o_unstable = 0; o_ready_after = 0; o_to = 1;
    o_addr = '0; o_wdata = '0; o_ld = '0; o_rd = '0; o_fin_addr = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (bus.write_enable && bus.read_enable) o_both = 1'b1;
      if (bus.write_enable || bus.read_enable) begin
        if (en_n > 0 && (bus.address !== o_addr || bus.write_data !== o_wdata)) o_unstable = 1'b1;
        en_n++;
        o_addr  = bus.address;
        o_wdata = bus.write_data;
        if (bus.write_enable) o_we++;
        else o_re++;
        if (en_n > wait_n) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = rdata;
        end
      end
      if (o_done_n > 0) begin
        o_ready_after = bus.instr_ready;
        if (bus.done === 1'b1) o_done_n++;
        o_to = 1'b0;
        break;
      end
      if (bus.done === 1'b1) begin
        o_done_n   = 1;
        o_done_cyc = c;
        o_err      = bus.err;
        o_ld       = bus.load_data;
        o_rd       = bus.load_rd;
        o_fin_addr = bus.address;
      end
    end
    bus.mem_ready = 1'b0;
    tests++;
    if (o_to) begin
      fails++;
      $display("FAIL done_wait: no done/ready within budget (got done_n=%0d, need 1)", o_done_n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({bus.write_enable, bus.read_enable, bus.done, bus.err, bus.instr_ready} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b need 00000", {bus.write_enable, bus.read_enable,
               bus.done, bus.err, bus.instr_ready});
    end
    tests++;
    if ({bus.address, bus.write_data, bus.load_data, bus.load_rd} !== '0) begin
      fails++;
      $display("FAIL reset_data: got addr=%h wd=%h ld=%h rd=%0d need all 0",
               bus.address, bus.write_data, bus.load_data, bus.load_rd);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b need 1", bus.instr_ready);
    end
  endtask

  task automatic test_sw_basic;
    exp_t e;
    sb.push_back('{addr: 32'h4, wdata: 32'h12345678, ld: 0, rd: 0, we_n: 1, re_n: 0,
                   done_cyc: 3, err: 1'b0});
    run_instr(OP_SW, 5'd2, 16'h0004, 32'h0, 32'h12345678, 0, 32'h0);
    e = sb.pop_front();
    tests++; if (o_addr !== e.addr) begin fails++; $display("FAIL sw1_addr: got %h need %h", o_addr, e.addr); end
    tests++; if (o_wdata !== e.wdata) begin fails++; $display("FAIL sw1_wdata: got %h need %h", o_wdata, e.wdata); end
    tests++; if (o_we !== e.we_n || o_re !== e.re_n) begin fails++; $display("FAIL sw1_en: got we=%0d re=%0d need we=%0d re=%0d", o_we, o_re, e.we_n, e.re_n); end
    tests++; if (o_done_cyc !== e.done_cyc || o_err !== e.err) begin fails++; $display("FAIL sw1_done: got cyc=%0d err=%b need cyc=%0d err=%b", o_done_cyc, o_err, e.done_cyc, e.err); end
    tests++; if (o_done_n !== 1 || o_ready_after !== 1'b1) begin fails++; $display("FAIL sw1_pulse: got done_n=%0d ready=%b need 1 1", o_done_n, o_ready_after); end
  endtask

  task automatic test_sw_wait;
    exp_t e;
    sb.push_back('{addr: 32'h3C, wdata: 32'hABCDEF01, ld: 0, rd: 0, we_n: 4, re_n: 0,
                   done_cyc: 6, err: 1'b0});
    run_instr(OP_SW, 5'd4, 16'h0020, 32'h1C, 32'hABCDEF01, 3, 32'h0);
    e = sb.pop_front();
    tests++; if (o_addr !== e.addr || o_wdata !== e.wdata) begin fails++; $display("FAIL sw2_bus: got %h/%h need %h/%h", o_addr, o_wdata, e.addr, e.wdata); end
    tests++; if (o_we !== e.we_n || o_unstable !== 1'b0) begin fails++; $display("FAIL sw2_hold: got we=%0d unstable=%b need %0d 0", o_we, o_unstable, e.we_n); end
    tests++; if (o_done_cyc !== e.done_cyc || o_err !== e.err) begin fails++; $display("FAIL sw2_done: got cyc=%0d err=%b need cyc=%0d err=%b", o_done_cyc, o_err, e.done_cyc, e.err); end
  endtask

  task automatic test_lw;
    exp_t e;
    sb.push_back('{addr: 32'hFC, wdata: 0, ld: 32'hDEADBEEF, rd: 5'd9, we_n: 0, re_n: 1,
                   done_cyc: 3, err: 1'b0});
    run_instr(OP_LW, 5'd9, 16'hFFFC, 32'h100, 32'h5A5A5A5A, 0, 32'hDEADBEEF);
    e = sb.pop_front();
    tests++; if (o_addr !== e.addr) begin fails++; $display("FAIL lw_addr: got %h need %h", o_addr, e.addr); end
    tests++; if (o_re !== e.re_n || o_we !== e.we_n || o_both) begin fails++; $display("FAIL lw_en: got re=%0d we=%0d need re=%0d we=%0d", o_re, o_we, e.re_n, e.we_n); end
    tests++; if (o_ld !== e.ld || o_rd !== e.rd) begin fails++; $display("FAIL lw_data: got %h rd=%0d need %h rd=%0d", o_ld, o_rd, e.ld, e.rd); end
    tests++; if (o_done_cyc !== e.done_cyc || o_err !== e.err) begin fails++; $display("FAIL lw_done: got cyc=%0d err=%b need cyc=%0d err=%b", o_done_cyc, o_err, e.done_cyc, e.err); end
  endtask

  task automatic test_timeout;
    exp_t e;
    sb.push_back('{addr: 32'h80, wdata: 32'h77, ld: 32'hDEADBEEF, rd: 5'd9, we_n: 15,
                   re_n: 0, done_cyc: 17, err: 1'b1});
    run_instr(OP_SW, 5'd1, 16'h0000, 32'h80, 32'h77, 1000, 32'h0);
    e = sb.pop_front();
    tests++; if (o_we !== e.we_n) begin fails++; $display("FAIL to_we: got %0d cycles need %0d", o_we, e.we_n); end
    tests++; if (o_done_cyc !== e.done_cyc || o_err !== e.err) begin fails++; $display("FAIL to_done: got cyc=%0d err=%b need cyc=%0d err=%b", o_done_cyc, o_err, e.done_cyc, e.err); end
    tests++; if (o_ready_after !== 1'b1 || o_done_n !== 1) begin fails++; $display("FAIL to_ready: got ready=%b done_n=%0d need 1 1", o_ready_after, o_done_n); end
    tests++; if (o_ld !== e.ld || o_rd !== e.rd) begin fails++; $display("FAIL to_load_kept: got %h rd=%0d need %h rd=%0d", o_ld, o_rd, e.ld, e.rd); end
  endtask

  task automatic test_reset_mid_req;
    int guard = 0;
    int dn    = 0;
    @(negedge clk);
    while (bus.instr_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    bus.instruction = {OP_SW, 5'd0, 5'd3, 16'h0000};
    bus.Read_data1  = 32'h40;
    bus.Read_data2  = 32'h55;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    guard = 0;
    while (bus.write_enable !== 1'b1 && guard < 10) begin @(negedge clk); guard++; end
    tests++;
    if (bus.write_enable !== 1'b1) begin fails++; $display("FAIL rst_mid_we: got %b need 1", bus.write_enable); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({bus.write_enable, bus.read_enable, bus.done} !== 3'b000) begin
      fails++;
      $display("FAIL rst_mid_drop: got we/re/done=%b need 000", {bus.write_enable, bus.read_enable, bus.done});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    tests++;
    if (dn !== 0 || bus.instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_after: got done_n=%0d ready=%b need 0 1", dn, bus.instr_ready);
    end
  endtask

  task automatic test_nonmem;
    exp_t e;
    run_instr(OP_LW, 5'd12, 16'h0010, 32'h200, 32'h0, 0, 32'hCAFEF00D);
    sb.push_back('{addr: 32'h210, wdata: 0, ld: 32'hCAFEF00D, rd: 5'd12, we_n: 0, re_n: 0,
                   done_cyc: 1, err: 1'b0});
    run_instr(6'b000000, 5'd5, 16'h1234, 32'h999, 32'h0, 0, 32'h0);
    e = sb.pop_front();
    tests++; if (o_we !== 0 || o_re !== 0) begin fails++; $display("FAIL nm_en: got we=%0d re=%0d need 0 0", o_we, o_re); end
    tests++; if (o_done_cyc !== e.done_cyc || o_err !== e.err || o_ready_after !== 1'b1) begin fails++; $display("FAIL nm_done: got cyc=%0d err=%b rdy=%b need cyc=%0d err=%b rdy=1", o_done_cyc, o_err, o_ready_after, e.done_cyc, e.err); end
    tests++; if (o_fin_addr !== e.addr || o_ld !== e.ld || o_rd !== e.rd) begin fails++; $display("FAIL nm_hold: got %h %h %0d need %h %h %0d", o_fin_addr, o_ld, o_rd, e.addr, e.ld, e.rd); end
  endtask

  task automatic test_misalign;
    exp_t e;
`ifdef MISALIGN_TRAP_EN
    sb.push_back('{addr: 32'h2, wdata: 0, ld: 0, rd: 0, we_n: 0, re_n: 0, done_cyc: 2, err: 1'b1});
`else
    sb.push_back('{addr: 32'h2, wdata: 0, ld: 0, rd: 0, we_n: 1, re_n: 0, done_cyc: 3, err: 1'b0});
`endif
    run_instr(OP_SW, 5'd6, 16'h0002, 32'h0, 32'h11112222, 0, 32'h0);
    e = sb.pop_front();
    tests++; if (o_fin_addr !== e.addr) begin fails++; $display("FAIL mis_addr: got %h need %h", o_fin_addr, e.addr); end
    tests++; if (o_we !== e.we_n || o_re !== e.re_n) begin fails++; $display("FAIL mis_en: got we=%0d re=%0d need %0d %0d", o_we, o_re, e.we_n, e.re_n); end
    tests++; if (o_done_cyc !== e.done_cyc || o_err !== e.err) begin fails++; $display("FAIL mis_done: got cyc=%0d err=%b need cyc=%0d err=%b", o_done_cyc, o_err, e.done_cyc, e.err); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [31:0] rd1;
    for (int i = 0; i < 4; i++) begin
      rd1 = $urandom & 32'hFFFF_FFFC;
      if (i % 2 == 0) begin
        sb.push_back('{addr: rd1 + 32'hFFFF_FFF8, wdata: 0, ld: 32'hA0000000 + i, rd: 5'(i + 20),
                       we_n: 0, re_n: 1, done_cyc: 3, err: 1'b0});
        run_instr(OP_LW, 5'(i + 20), 16'hFFF8, rd1, 32'h0, 0, 32'hA0000000 + i);
      end else begin
        sb.push_back('{addr: rd1 + 32'h0000_7FFC, wdata: 32'hB0000000 + i, ld: 32'hA0000000 + i - 1,
                       rd: 5'(i + 19), we_n: 1, re_n: 0, done_cyc: 3, err: 1'b0});
        run_instr(OP_SW, 5'd0, 16'h7FFC, rd1, 32'hB0000000 + i, 0, 32'h0);
      end
      e = sb.pop_front();
      tests++;
      if (o_addr !== e.addr || o_we !== e.we_n || o_re !== e.re_n || o_done_cyc !== e.done_cyc) begin
        fails++;
        $display("FAIL b2b_%0d_req: got addr=%h we=%0d re=%0d cyc=%0d need %h %0d %0d %0d",
                 i, o_addr, o_we, o_re, o_done_cyc, e.addr, e.we_n, e.re_n, e.done_cyc);
      end
      tests++;
      if (o_ld !== e.ld || o_rd !== e.rd || (e.we_n == 1 && o_wdata !== e.wdata)) begin
        fails++;
        $display("FAIL b2b_%0d_data: got ld=%h rd=%0d wd=%h need %h %0d %h",
                 i, o_ld, o_rd, o_wdata, e.ld, e.rd, e.wdata);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instruction = '0;
    bus.Read_data1  = '0;
    bus.Read_data2  = '0;
    bus.mem_ready   = 1'b0;
    bus.mem_rdata   = '0;
    test_reset();
    test_sw_basic();
    test_sw_wait();
    test_lw();
    test_timeout();
    test_reset_mid_req();
    test_nonmem();
    test_misalign();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
